// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared types and constants for the nibble-serial adder
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } nsa_state_t;

endpackage

// File: rtl/add4_slice.sv
// rtl/add4_slice.sv - combinational 4-bit ripple-carry adder slice
module add4_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] ain,
    input  logic [NIBBLE_W-1:0] bin,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]   = ain[i] ^ bin[i] ^ c[i];
        assign c[i + 1] = (ain[i] & bin[i]) | (c[i] & (ain[i] ^ bin[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder, one nibble per cycle, LS nibble first
// Optional subtract mode (op_sub port) when SERIAL_ADD_SUB_EN is defined.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WORDS = 4
)
(
    input  logic                      clk,
    input  logic                      rst,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                      op_sub,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*WORDS-1:0] a,
    input  logic [NIBBLE_W*WORDS-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*WORDS-1:0] sum,
    output logic                      cout,
    output logic                      busy
);

    localparam int              W        = NIBBLE_W * WORDS;
    localparam int              IW       = $clog2(WORDS) + 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);

    nsa_state_t         state;
    nsa_state_t         state_nxt;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;
    logic               carry;
    logic               cout_q;
    logic [IW-1:0]      idx;
    logic               accept;
    logic               sub_sel;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_cout;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign nib_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

    add4_slice u_slice (
        .ain  (nib_a),
        .bin  (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at capture and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b ^ {W{sub_sel}};
            carry <= sub_sel;
            idx   <= '0;
        end else if (state == S_RUN) begin
            sum_q[NIBBLE_W*idx +: NIBBLE_W] <= nib_sum;
            carry <= nib_cout;
            idx   <= idx + IW'(1);
            if (idx == LAST_IDX) begin
                cout_q <= nib_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
